// File: rtl/coax_tx.sv
// coax_tx: Manchester bit serializer for coax frames.
// Takes 10-bit words over a ready/strobe handshake. Each frame is five
// quiesce cells, a code violation, then one or more 12-cell words
// (sync, ten data bits MSB first, even parity), a '0' end cell and a
// one-cell high hold. A word accepted during the PARITY cell is chained
// into the same frame with no gap.
// All outputs are registered from next-state values, so tx has no
// glitches and the first quiesce half-cell appears on the cycle after
// the word is accepted.

module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int HALF_CELL = CLOCKS_PER_BIT / 2;
  localparam int CV_HALF   = 3 * CLOCKS_PER_BIT / 2;
  localparam int CNT_W     = $clog2(CV_HALF + 1);

  localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CV_LAST   = CNT_W'(CV_HALF - 1);
  localparam logic [CNT_W-1:0] HALF_MARK = CNT_W'(HALF_CELL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] QUIESCE_LAST = 4'd4;
  localparam logic [3:0] DATA_LAST    = 4'd9;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_QUIESCE   = 3'd1;
  localparam logic [2:0] S_CODE_VIOL = 3'd2;
  localparam logic [2:0] S_SYNC      = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_PARITY    = 3'd5;
  localparam logic [2:0] S_END_SYNC  = 3'd6;
  localparam logic [2:0] S_END_HOLD  = 3'd7;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cellCnt_q,   cellCnt_d;
  logic [3:0]       bitCnt_q,    bitCnt_d;
  logic [9:0]       hold_q,      hold_d;
  logic             holdValid_q, holdValid_d;
  logic [9:0]       shift_q,     shift_d;
  logic             parity_q,    parity_d;
  logic             ready_q,     ready_d;
  logic             active_q,    active_d;
  logic             tx_q,        tx_d;

  logic       accept;
  logic       cellEnd;
  logic       cvEnd;
  logic [9:0] nextWord;

  // Line level for a given state position: Manchester cells drive the
  // inverted bit in the first half and the true bit in the second half;
  // the code violation and end hold are flat levels.
  function automatic logic lineLevel(
    input logic [2:0]       st,
    input logic [CNT_W-1:0] cnt,
    input logic [3:0]       bits,
    input logic             msb,
    input logic             par
  );
    logic cellBit;
    logic manch;
    logic level;
    cellBit = 1'b0;
    manch   = 1'b1;
    level   = 1'b0;
    case (st)
      S_IDLE:      manch = 1'b0;
      S_QUIESCE:   cellBit = 1'b1;
      S_CODE_VIOL: begin
        manch = 1'b0;
        level = bits[0];
      end
      S_SYNC:      cellBit = 1'b1;
      S_DATA:      cellBit = msb;
      S_PARITY:    cellBit = par;
      S_END_SYNC:  cellBit = 1'b0;
      S_END_HOLD:  begin
        manch = 1'b0;
        level = 1'b1;
      end
      default:     manch = 1'b0;
    endcase
    if (manch) begin
      level = (cnt < HALF_MARK) ? ~cellBit : cellBit;
    end
    return level;
  endfunction

  assign accept   = strobe && ready_q;
  assign cellEnd  = (cellCnt_q == CELL_LAST);
  assign cvEnd    = (cellCnt_q == CV_LAST);
  assign nextWord = holdValid_q ? hold_q : data;

  // Frame sequencing: cell/half-cell timing, word holding and chaining.
  always_comb begin
    state_d     = state_q;
    cellCnt_d   = cellCnt_q + CNT_ONE;
    bitCnt_d    = bitCnt_q;
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    shift_d     = shift_q;
    parity_d    = parity_q;

    case (state_q)
      S_IDLE: begin
        cellCnt_d = '0;
        bitCnt_d  = '0;
        if (accept) begin
          hold_d      = data;
          holdValid_d = 1'b1;
          state_d     = S_QUIESCE;
        end
      end

      S_QUIESCE: begin
        if (cellEnd) begin
          cellCnt_d = '0;
          if (bitCnt_q == QUIESCE_LAST) begin
            bitCnt_d = '0;
            state_d  = S_CODE_VIOL;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end

      S_CODE_VIOL: begin
        if (cvEnd) begin
          cellCnt_d = '0;
          if (bitCnt_q[0]) begin
            bitCnt_d    = '0;
            state_d     = S_SYNC;
            shift_d     = hold_q;
            parity_d    = ~(^hold_q);
            holdValid_d = 1'b0;
          end else begin
            bitCnt_d = 4'd1;
          end
        end
      end

      S_SYNC: begin
        if (cellEnd) begin
          cellCnt_d = '0;
          bitCnt_d  = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (cellEnd) begin
          cellCnt_d = '0;
          shift_d   = {shift_q[8:0], 1'b0};
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            state_d  = S_PARITY;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (accept) begin
          hold_d      = data;
          holdValid_d = 1'b1;
        end
        if (cellEnd) begin
          cellCnt_d = '0;
          bitCnt_d  = '0;
          if (holdValid_q || accept) begin
            state_d     = S_SYNC;
            shift_d     = nextWord;
            parity_d    = ~(^nextWord);
            holdValid_d = 1'b0;
          end else begin
            state_d = S_END_SYNC;
          end
        end
      end

      S_END_SYNC: begin
        if (cellEnd) begin
          cellCnt_d = '0;
          state_d   = S_END_HOLD;
        end
      end

      S_END_HOLD: begin
        if (cellEnd) begin
          cellCnt_d = '0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cellCnt_d   = '0;
        bitCnt_d    = '0;
        holdValid_d = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    tx_d     = lineLevel(state_d, cellCnt_d, bitCnt_d, shift_d[9], parity_d);
    active_d = (state_d != S_IDLE);
    ready_d  = (state_d == S_IDLE) || ((state_d == S_PARITY) && !holdValid_d);
  end

  // State and output registers; reset aborts any frame on the spot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cellCnt_q   <= '0;
      bitCnt_q    <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cellCnt_q   <= cellCnt_d;
      bitCnt_q    <= bitCnt_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      tx_q        <= tx_d;
    end
  end

  assign ready  = ready_q;
  assign active = active_q;
  assign tx     = tx_q;

endmodule

// File: tb/tb_coax_tx.sv
// tb_coax_tx: directed bench for coax_tx with a waveform-level model.
// The model builds each frame as a list of per-clock line levels from
// the framing rules and appends words or the end sequence as the frame
// runs out; a compare process checks tx/active/ready every cycle.

module tb_coax_tx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int CVH  = 3 * CPB / 2;

  logic       clk;
  logic       reset;
  logic [9:0] data;
  logic       strobe;
  logic       ready;
  logic       active;
  logic       tx;

  int totalChecks = 0;
  int badChecks   = 0;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .strobe (strobe),
    .ready  (ready),
    .active (active),
    .tx     (tx)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: the expected line levels of the current frame.
  bit         lvl[$];
  int         idx      = 0;
  bit         inFrame  = 0;
  bit         ending   = 0;
  bit         held     = 0;
  logic [9:0] heldWord = '0;
  int         parStart = -1;
  int         parEnd   = -1;
  bit         mReady   = 1;
  bit         mActive  = 0;
  bit         mTx      = 0;

  // Frame capture from the DUT for the literal checks.
  bit capTx[0:1023];
  int frameLen  = 0;
  int lastLen   = 0;
  int frameDone = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pushCell(input bit b);
    for (int i = 0; i < HALF; i++) lvl.push_back(~b);
    for (int i = 0; i < HALF; i++) lvl.push_back(b);
  endfunction

  function automatic void pushWord(input logic [9:0] w);
    int ones;
    pushCell(1'b1);
    for (int i = 9; i >= 0; i--) pushCell(w[i]);
    ones     = 1 + $countones(w);
    parStart = lvl.size();
    pushCell((ones % 2) == 1);
    parEnd   = lvl.size() - 1;
  endfunction

  function automatic void startFrame(input logic [9:0] w);
    lvl.delete();
    for (int c = 0; c < 5; c++) pushCell(1'b1);
    for (int i = 0; i < CVH; i++) lvl.push_back(1'b0);
    for (int i = 0; i < CVH; i++) lvl.push_back(1'b1);
    pushWord(w);
    idx     = 0;
    inFrame = 1;
    ending  = 0;
    held    = 0;
  endfunction

  function automatic void modelStep(input bit r, input bit s, input logic [9:0] d);
    bit acc;
    if (!r) begin
      inFrame = 0;
      held    = 0;
      ending  = 0;
    end else begin
      acc = s && mReady;
      if (!inFrame) begin
        if (acc) startFrame(d);
      end else begin
        if (acc) begin
          held     = 1;
          heldWord = d;
        end
        idx++;
        if (idx >= lvl.size()) begin
          if (ending) begin
            inFrame = 0;
          end else if (held) begin
            pushWord(heldWord);
            held = 0;
          end else begin
            pushCell(1'b0);
            for (int i = 0; i < CPB; i++) lvl.push_back(1'b1);
            ending   = 1;
            parStart = -1;
            parEnd   = -1;
          end
        end
      end
    end
    mActive = inFrame;
    mTx     = inFrame ? lvl[idx] : 1'b0;
    mReady  = !inFrame || (!held && idx >= parStart && idx <= parEnd);
  endfunction

  // Advance the model on each edge, then compare the DUT mid-cycle and
  // record frame captures and active lengths.
  always begin
    @(posedge clk);
    modelStep(reset, strobe, data);
    #3;
    checkOutput("tx", tx, mTx);
    checkOutput("active", active, mActive);
    checkOutput("ready", ready, mReady);
    if (active === 1'b1) begin
      if (frameLen < 1024) capTx[frameLen] = tx;
      frameLen++;
    end else if (frameLen != 0) begin
      lastLen  = frameLen;
      frameLen = 0;
      frameDone++;
    end
  end

  task automatic applyStimulus(input bit s, input logic [9:0] d);
    @(negedge clk);
    strobe = s;
    data   = d;
  endtask

  task automatic sendWord(input logic [9:0] w);
    applyStimulus(1'b1, w);
    applyStimulus(1'b0, w);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitReady(input bit level, input string name);
    int  n;
    bit  found;
    n     = 0;
    found = 0;
    while (!found && n < 1000) begin
      @(posedge clk);
      #3;
      if (ready === level) found = 1;
      n++;
    end
    if (!found) checkOutput(name, 32'd0, 32'd1);
  endtask

  task automatic waitFrameEnd(input int expLen, input string name);
    int start;
    int n;
    start = frameDone;
    n     = 0;
    while (frameDone == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (frameDone == start) checkOutput({name, "Timeout"}, 32'd0, 32'd1);
    else checkOutput(name, lastLen, expLen);
  endtask

  localparam logic [9:0] W1 = 10'b0101110101;
  localparam logic [9:0] W2 = 10'b1010001110;
  localparam logic [9:0] W3 = 10'b1100110011;

  initial begin
    logic [18:0] dec;
    logic [23:0] cvBits;
    int          k;

    reset  = 1'b0;
    strobe = 1'b0;
    data   = '0;
    waitCycles(3);
    checkOutput("resetTx", tx, 1'b0);
    checkOutput("resetActive", active, 1'b0);
    checkOutput("resetReady", ready, 1'b1);
    reset = 1'b1;
    waitCycles(3);

    $display("[TB] single word");
    sendWord(W1);
    waitFrameEnd(176, "lenSingle");
    waitCycles(3);
    checkOutput("idleTxAfter", tx, 1'b0);
    k = 18;
    for (int c = 0; c < 22; c++) begin
      if (c < 5 || c > 7) begin
        dec[k] = capTx[c * CPB + HALF];
        k--;
      end
    end
    checkOutput("decodeCells", dec, 19'b1111110101110101101);
    for (int i = 0; i < 24; i++) cvBits[23 - i] = capTx[40 + i];
    checkOutput("codeViolation", cvBits, 24'h000FFF);
    checkOutput("firstHalfSync", capTx[64], 1'b0);

    $display("[TB] three chained words");
    sendWord(W1);
    waitReady(1'b1, "readyChain1");
    sendWord(W2);
    waitReady(1'b1, "readyChain2");
    sendWord(W1);
    waitFrameEnd(368, "lenThree");
    checkOutput("parityW2", capTx[(8 + 12 + 11) * CPB + HALF], 1'b0);
    waitCycles(4);

    $display("[TB] strobe while busy");
    sendWord(W1);
    waitCycles(44);
    sendWord(W2);
    waitFrameEnd(176, "lenDropped");
    waitCycles(4);
    sendWord(W1);
    waitCycles(44);
    sendWord(W2);
    waitReady(1'b1, "readyAppend");
    sendWord(W3);
    waitFrameEnd(272, "lenAppend");
    waitCycles(4);

    $display("[TB] late word");
    sendWord(W2);
    waitReady(1'b1, "readyLateParity");
    waitReady(1'b0, "readyLateEnd");
    sendWord(W3);
    waitFrameEnd(176, "lenLate");
    waitCycles(2);
    checkOutput("lateIdleTx", tx, 1'b0);
    sendWord(W3);
    waitFrameEnd(176, "lenFresh");
    waitCycles(4);

    $display("[TB] reset mid-frame");
    sendWord(W1);
    waitCycles(103);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("abortTx", tx, 1'b0);
    checkOutput("abortActive", active, 1'b0);
    checkOutput("abortReady", ready, 1'b1);
    waitCycles(2);
    sendWord(W1);
    waitFrameEnd(176, "lenAfterReset");
    waitCycles(4);

    $display("[TB] strobe on last parity cycle");
    sendWord(W2);
    waitReady(1'b1, "readyLastParity");
    repeat (7) @(negedge clk);
    sendWord(W1);
    waitFrameEnd(272, "lenLastParity");
    checkOutput("chainedSyncFirstHalf", capTx[20 * CPB], 1'b0);
    checkOutput("chainedSyncSecondHalf", capTx[20 * CPB + HALF], 1'b1);
    waitCycles(5);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/coax_tx.md
Name: coax_tx

Overview:
Bit-level serializer that sits directly downstream of the buffered transmit FIFO. It accepts 10-bit words over a ready/strobe handshake and emits one complete coax frame on a single Manchester-encoded line: start sequence, then each word framed with a sync bit and a parity bit, then an end sequence. Consecutive words presented in time are packed into one frame with no gaps. When no word is pending, the frame is closed.

Parameters:
CLOCKS_PER_BIT, 8, clocks per bit cell; must be even and >= 4; half-cell = CLOCKS_PER_BIT/2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
data  input  10  word to transmit, MSB sent first
strobe  input  1  word valid; accepted on a cycle where strobe && ready
ready  output  1  block can accept a word this cycle
active  output  1  high for the whole frame, from the first quiesce cell through the last end-sequence cell
tx  output  1  Manchester line output; 0 when idle

Behaviour:
- Reset (reset==0 at a clk edge):
  - tx=0, active=0, ready=1.
  - Holding register cleared; state=IDLE.
  - Reset mid-frame aborts the frame immediately; there is no end sequence.
- Bit encoding for bit b:
  - First half-cell drives ~b, second half-cell drives b.
  - So 1 is a mid-cell rising edge and 0 is a mid-cell falling edge.
- States: IDLE, QUIESCE, CODE_VIOLATION, SYNC, DATA, PARITY, END_SYNC, END_HOLD.
- IDLE:
  - ready=1, active=0, tx=0.
  - Accepting a word latches data into the holding register and moves to QUIESCE.
  - First QUIESCE half-cell drives tx on the next cycle (latency 1 clk).
  - active rises on that same cycle.
- QUIESCE: five bit cells of '1'.
- CODE_VIOLATION:
  - tx=0 for 3*CLOCKS_PER_BIT/2 clocks, then tx=1 for 3*CLOCKS_PER_BIT/2 clocks.
  - There is no mid-cell transition inside either half.
- Word, 12 cells in order:
  - SYNC: one cell of '1'.
  - DATA: 10 cells, data[9] first.
  - PARITY: one cell; parity = 1 ^ (^data), so the 12-bit ones count including sync is even.
- Loading the shift register:
  - The shift register loads from the holding register at entry to SYNC.
  - The holding register is freed at that point.
- ready during a frame:
  - ready=1 throughout the PARITY cell while the holding register is empty, and 0 elsewhere within the frame.
  - Only one word can be held.
- End of PARITY cell:
  - If a word is held, go to SYNC with no idle gap.
  - Otherwise go to END_SYNC.
- END_SYNC: one cell of '0'.
- END_HOLD:
  - tx=1 for CLOCKS_PER_BIT clocks.
  - Then IDLE: tx=0, active=0, ready=1.
- strobe while ready==0: ignored, word dropped, no state change.
- strobe on the last cycle of PARITY: accepted, and the frame continues.
- strobe on the first cycle of END_SYNC: ignored.
- Frame length in clocks = CLOCKS_PER_BIT*(5+3+12*N+2) for N words.
- Counters:
  - Cell counter is sized ceil(log2(3*CLOCKS_PER_BIT/2+1)).
  - Bit counter is 4 bits.
  - Counters roll over only on state transitions.

Test Plan:
1. Single word, CLOCKS_PER_BIT=8:
   - Stimulus: strobe 0101110101 in IDLE.
   - active high for exactly 176 clks.
   - Decoded cells: 11111, CV, 1, 0101110101, parity 1, end 0, hold high.
   - tx=0 afterwards.
2. Three words:
   - Stimulus: 0101110101, then 1010001110 (parity 0), then 0101110101, each strobed on the first ready cycle.
   - active for 368 clks.
   - Word SYNCs are contiguous, with no extra cells between PARITY and the next SYNC.
3. Strobe while busy:
   - Stimulus: strobe a second word during CODE_VIOLATION (ready=0).
   - Word is dropped; frame length 176 clks.
   - The word strobed later during PARITY is accepted and appended.
4. Late word:
   - Stimulus: strobe on the first cycle of END_SYNC.
   - Ignored; frame ends.
   - The same word strobed in IDLE afterwards starts a fresh frame with QUIESCE.
5. Reset mid-frame:
   - Stimulus: drive reset=0 for one clk during DATA bit 4.
   - Next cycle: tx=0, active=0, ready=1.
   - A new strobe produces a full, correct 176-clk frame.
6. Boundary timing:
   - Stimulus: strobe on the last cycle of PARITY.
   - The next word's SYNC starts on the immediately following clk.
